// File: rtl/doodle_pkg.sv
// Shared definitions for the accelerometer tilt path: tilt state codes, X-axis field
// position inside the SPI sample word, and the LED thermometer helper.
package doodle_pkg;

  localparam logic [1:0] TILT_CENTER = 2'd0;
  localparam logic [1:0] TILT_LEFT   = 2'd1;
  localparam logic [1:0] TILT_RIGHT  = 2'd2;

  localparam int unsigned ACL_X_MSB = 9;
  localparam int unsigned ACL_X_LSB = 5;

  // Bar length is the intensity rounded up to quarters of 16 (0..4 lit segments).
  function automatic logic [3:0] therm_bar(input logic [3:0] intensity);
    logic [4:0] t;
    t = {1'b0, intensity} + 5'd3;
    case (t[4:2])
      3'd0:    therm_bar = 4'b0000;
      3'd1:    therm_bar = 4'b0001;
      3'd2:    therm_bar = 4'b0011;
      3'd3:    therm_bar = 4'b0111;
      default: therm_bar = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/acl_cs_sync_edge.sv
// Three-flop synchronizer for an asynchronous level with a one-cycle rising-edge pulse.
// Reused for chip select and push-button inputs.
module acl_cs_sync_edge (
  input  logic ClkPort,
  input  logic Reset,
  input  logic i_async,
  output logic o_edge
);

  logic [2:0] r_sync;

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_async};
    end
  end

  assign o_edge = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/acl_tilt_filter.sv
// Brings accelerometer X samples into the ClkPort domain, averages them over a sliding
// window and turns the average into hysteretic tilt flags, intensity and LED bars.
module acl_tilt_filter
  import doodle_pkg::*;
#(
  parameter int unsigned AVG_LOG2       = 3,
  parameter int unsigned ENTER_TH       = 4,
  parameter int unsigned EXIT_TH        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic        acl_cs,
  input  logic [14:0] acl_data,
  output logic        out_valid,
  output logic        tilt_left,
  output logic        tilt_right,
  output logic [3:0]  tilt_intensity,
  output logic [3:0]  left_leds,
  output logic [3:0]  right_leds,
  output logic        stale
);

  localparam int          DEPTH   = 1 << AVG_LOG2;
  localparam int unsigned SUM_W   = 5 + AVG_LOG2;
  localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam int          ENTER_I = int'(ENTER_TH);
  localparam int          EXIT_I  = int'(EXIT_TH);

  logic w_edge;
  logic w_acl_unused;

  logic signed [4:0]       r_x;
  logic                    r_x_v;
  logic signed [4:0]       r_buf [DEPTH];
  logic [AVG_LOG2-1:0]     r_wp;
  logic signed [SUM_W-1:0] r_sum;
  logic                    r_sum_v;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_to_hit;

  logic signed [31:0] w_avg;
  logic signed [31:0] w_abs;
  logic [3:0]         w_int;
  logic [3:0]         w_bar;
  logic [1:0]         w_state_d;

  logic [1:0] r_state;
  logic       r_valid;
  logic       r_left;
  logic       r_right;
  logic [3:0] r_int;
  logic [3:0] r_lleds;
  logic [3:0] r_rleds;
  logic       r_stale;

  acl_cs_sync_edge u_cs_sync (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .i_async (acl_cs),
    .o_edge  (w_edge)
  );

  assign w_acl_unused = ^{acl_data[14:10], acl_data[4:0]};

  // acl_data is stable while CS is high, so sampling it one cycle after the edge is safe.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_x   <= '0;
      r_x_v <= 1'b0;
    end else begin
      r_x_v <= w_edge;
      if (w_edge) begin
        r_x <= $signed(acl_data[ACL_X_MSB:ACL_X_LSB]);
      end
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_wp    <= '0;
      r_sum   <= '0;
      r_sum_v <= 1'b0;
    end else begin
      r_sum_v <= r_x_v;
      if (r_x_v) begin
        r_sum      <= r_sum + SUM_W'(r_x) - SUM_W'(r_buf[r_wp]);
        r_buf[r_wp] <= r_x;
        r_wp       <= r_wp + 1'b1;
      end
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= '0;
    end else if (r_cnt != TO_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires once, on the cycle the counter saturates.
  assign w_to_hit = !w_edge && (r_cnt == TO_MAX - 1'b1);

  assign w_avg = 32'(r_sum) >>> AVG_LOG2;
  assign w_abs = w_avg[31] ? -w_avg : w_avg;
  assign w_int = (w_abs > 32'sd15) ? 4'd15 : w_abs[3:0];
  assign w_bar = therm_bar(w_int);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      TILT_CENTER: begin
        if (w_avg >= ENTER_I)       w_state_d = TILT_LEFT;
        else if (w_avg <= -ENTER_I) w_state_d = TILT_RIGHT;
      end
      TILT_LEFT: begin
        if (w_avg <= -ENTER_I)      w_state_d = TILT_RIGHT;
        else if (w_avg < EXIT_I)    w_state_d = TILT_CENTER;
      end
      TILT_RIGHT: begin
        if (w_avg >= ENTER_I)       w_state_d = TILT_LEFT;
        else if (w_avg > -EXIT_I)   w_state_d = TILT_CENTER;
      end
      default: w_state_d = TILT_CENTER;
    endcase
  end

  // A fresh average takes priority over a coincident timeout.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_state <= TILT_CENTER;
      r_valid <= 1'b0;
      r_left  <= 1'b0;
      r_right <= 1'b0;
      r_int   <= '0;
      r_lleds <= '0;
      r_rleds <= '0;
      r_stale <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_sum_v) begin
        r_valid <= 1'b1;
        r_stale <= 1'b0;
        r_state <= w_state_d;
        r_left  <= (w_state_d == TILT_LEFT);
        r_right <= (w_state_d == TILT_RIGHT);
        r_int   <= w_int;
        r_lleds <= (w_state_d == TILT_LEFT)  ? w_bar : 4'b0000;
        r_rleds <= (w_state_d == TILT_RIGHT) ? w_bar : 4'b0000;
      end else if (w_to_hit) begin
        r_stale <= 1'b1;
        r_state <= TILT_CENTER;
        r_left  <= 1'b0;
        r_right <= 1'b0;
        r_int   <= '0;
        r_lleds <= '0;
        r_rleds <= '0;
      end
    end
  end

  assign out_valid      = r_valid;
  assign tilt_left      = r_left;
  assign tilt_right     = r_right;
  assign tilt_intensity = r_int;
  assign left_leds      = r_lleds;
  assign right_leds     = r_rleds;
  assign stale          = r_stale;

endmodule

// File: tb/tb_acl_tilt_filter.sv
// Scoreboard bench for acl_tilt_filter: samples are driven on an unsynchronised ~4 MHz chip
// select, expected outputs come from a behavioural window/hysteresis model.
module tb_acl_tilt_filter;

  localparam int unsigned TO = 100;

  logic        ClkPort  = 1'b0;
  logic        Reset    = 1'b1;
  logic        acl_cs   = 1'b0;
  logic [14:0] acl_data = '0;
  logic        out_valid, tilt_left, tilt_right, stale;
  logic [3:0]  tilt_intensity, left_leds, right_leds;

  acl_tilt_filter #(
    .AVG_LOG2       (3),
    .ENTER_TH       (4),
    .EXIT_TH        (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .ClkPort        (ClkPort),
    .Reset          (Reset),
    .acl_cs         (acl_cs),
    .acl_data       (acl_data),
    .out_valid      (out_valid),
    .tilt_left      (tilt_left),
    .tilt_right     (tilt_right),
    .tilt_intensity (tilt_intensity),
    .left_leds      (left_leds),
    .right_leds     (right_leds),
    .stale          (stale)
  );

  always #5 ClkPort = ~ClkPort;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic       l;
    logic       r;
    logic [3:0] i;
    logic [3:0] ll;
    logic [3:0] rl;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_q[$];

  // Behavioural model: 0 = centre, 1 = left, 2 = right.
  int m_buf[8];
  int m_wp    = 0;
  int m_state = 0;

  function automatic void model_push(input int x);
    int sum, avg, mag, n;
    exp_t e;
    m_buf[m_wp] = x;
    m_wp = (m_wp + 1) % 8;
    sum = 0;
    foreach (m_buf[k]) sum += m_buf[k];
    avg = sum >>> 3;
    case (m_state)
      0: if (avg >= 4) m_state = 1; else if (avg <= -4) m_state = 2;
      1: if (avg <= -4) m_state = 2; else if (avg < 2) m_state = 0;
      default: if (avg >= 4) m_state = 1; else if (avg > -2) m_state = 0;
    endcase
    mag = (avg < 0) ? -avg : avg;
    if (mag > 15) mag = 15;
    n = (mag + 3) / 4;
    e.l  = (m_state == 1);
    e.r  = (m_state == 2);
    e.i  = 4'(mag);
    e.ll = (m_state == 1) ? 4'((1 << n) - 1) : 4'd0;
    e.rl = (m_state == 2) ? 4'((1 << n) - 1) : 4'd0;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    foreach (m_buf[k]) m_buf[k] = 0;
    m_wp    = 0;
    m_state = 0;
  endfunction

  // Independent view of the CS edge timing, used for the latency check.
  logic [2:0] t_sync = '0;
  int cyc       = 0;
  int last_edge = 0;
  int n_valid   = 0;

  always @(posedge ClkPort or posedge Reset) begin
    if (Reset) t_sync <= '0;
    else       t_sync <= {t_sync[1:0], acl_cs};
  end

  always @(posedge ClkPort) cyc <= cyc + 1;

  always @(negedge ClkPort) begin : mon
    exp_t e;
    int   ec;
    if (!Reset) begin
      if (t_sync[1] && !t_sync[2]) begin
        cyc_q.push_back(cyc + 3);
        last_edge = cyc;
      end
      if (out_valid) begin
        n_valid++;
        if (exp_q.size() == 0 || cyc_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          ec = cyc_q.pop_front();
          check("latency", cyc, ec);
          check("tilt_left", tilt_left, e.l);
          check("tilt_right", tilt_right, e.r);
          check("intensity", tilt_intensity, e.i);
          check("left_leds", left_leds, e.ll);
          check("right_leds", right_leds, e.rl);
          check("stale_on_valid", stale, 32'd0);
        end
      end
    end
  end

  task automatic send(input int x);
    @(negedge ClkPort);
    acl_data = {5'($urandom), 5'(x), 5'($urandom)};
    model_push(x);
    #($urandom_range(1, 4));
    acl_cs = 1'b1;
    #125;
    acl_cs = 1'b0;
    #120;
  endtask

  initial begin : wdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int waited;
    int v0;

    // Reset state and idle period
    #20;
    check("rst_outputs", {out_valid, tilt_left, tilt_right, stale, tilt_intensity,
                          left_leds, right_leds}, 32'd0);
    @(negedge ClkPort);
    Reset = 1'b0;
    repeat (99) @(posedge ClkPort);
    @(negedge ClkPort);
    check("idle_outputs", {out_valid, tilt_left, tilt_right, stale, tilt_intensity,
                           left_leds, right_leds}, 32'd0);

    // Steady right tilt
    repeat (8) send(-8);
    check("right_after_8", {tilt_right, tilt_intensity, right_leds}, {1'b1, 4'd8, 4'b0011});

    // Hysteresis back to centre
    repeat (6) send(0);
    check("still_right", tilt_right, 32'd1);
    send(0);
    check("centre_after_7", {tilt_right, right_leds}, 32'd0);

    // Saturation, then swing left
    repeat (8) send(-16);
    check("sat_intensity", tilt_intensity, 32'd15);
    check("sat_right_leds", right_leds, 32'hf);
    repeat (8) send(15);
    check("left_final", {tilt_left, tilt_intensity, left_leds}, {1'b1, 4'd15, 4'b1111});

    // Timeout with retained window
    waited = 0;
    while (!stale && waited < 300) begin
      @(negedge ClkPort);
      waited++;
    end
    check("stale_set", stale, 32'd1);
    check("stale_timing", cyc - last_edge, 32'd101);
    check("stale_outputs", {out_valid, tilt_left, tilt_right, tilt_intensity, left_leds,
                            right_leds}, 32'd0);
    m_state = 0;
    send(15);
    check("stale_cleared", stale, 32'd0);

    // Reset while a sample is in flight
    @(negedge ClkPort);
    acl_data = {5'd0, 5'(-8), 5'd0};
    model_push(-8);
    #2;
    acl_cs = 1'b1;
    waited = 0;
    while (!(t_sync[1] && !t_sync[2]) && waited < 20) begin
      @(negedge ClkPort);
      waited++;
    end
    check("edge_seen", waited < 20, 32'd1);
    @(posedge ClkPort);
    #2;
    Reset = 1'b1;
    #1;
    check("midpipe_rst_outputs", {out_valid, tilt_left, tilt_right, stale, tilt_intensity,
                                  left_leds, right_leds}, 32'd0);
    exp_q.delete();
    cyc_q.delete();
    model_reset();
    acl_cs = 1'b0;
    repeat (3) @(negedge ClkPort);
    v0 = n_valid;
    Reset = 1'b0;
    repeat (30) @(negedge ClkPort);
    check("no_valid_after_rst", n_valid - v0, 32'd0);
    send(-8);
    check("post_rst_intensity", tilt_intensity, 32'd1);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
